// File: rtl/prf_wr_arbiter.sv
// PRF write arbiter: one small FIFO per writeback requester, one round-robin
// arbiter per register-file bank, and registered bank write ports.
module prf_wr_arbiter #(
  parameter int unsigned WR_COUNT    = 8,
  parameter int unsigned BANK_COUNT  = 4,
  parameter int unsigned BUF_ENTRIES = 2
) (
  input  logic                                          CLK,
  input  logic                                          RST,
  input  logic [WR_COUNT-1:0]                           req_valid,
  input  logic [WR_COUNT-1:0][6:0]                      req_PR,
  input  logic [WR_COUNT-1:0][63:0]                     req_data,
  output logic [WR_COUNT-1:0]                           req_ready,
  output logic [BANK_COUNT-1:0]                         bank_wr_valid,
  output logic [BANK_COUNT-1:0][6-$clog2(BANK_COUNT):0] bank_wr_upper_PR,
  output logic [BANK_COUNT-1:0][63:0]                   bank_wr_data,
  output logic [BANK_COUNT-1:0][6:0]                    bank_wr_PR
);

  localparam int unsigned PrW   = 7;
  localparam int unsigned Xlen  = 64;
  localparam int unsigned BankW = $clog2(BANK_COUNT);
  localparam int unsigned PtrW  = (WR_COUNT > 1) ? $clog2(WR_COUNT) : 1;
  localparam int unsigned SumW  = PtrW + 1;
  localparam int unsigned SlotW = (BUF_ENTRIES > 1) ? $clog2(BUF_ENTRIES) : 1;
  localparam int unsigned CntW  = $clog2(BUF_ENTRIES + 1);

  logic [PrW-1:0]   fifo_pr_q   [WR_COUNT][BUF_ENTRIES];
  logic [Xlen-1:0]  fifo_data_q [WR_COUNT][BUF_ENTRIES];
  logic [SlotW-1:0] rd_slot_q   [WR_COUNT];
  logic [SlotW-1:0] wr_slot_q   [WR_COUNT];
  logic [CntW-1:0]  count_q     [WR_COUNT];
  logic [PtrW-1:0]  rr_ptr_q    [BANK_COUNT];

  logic [WR_COUNT-1:0]   not_full;
  logic [WR_COUNT-1:0]   head_valid;
  logic [WR_COUNT-1:0]   enq;
  logic [WR_COUNT-1:0]   deq;
  logic [PrW-1:0]        head_pr     [WR_COUNT];
  logic [Xlen-1:0]       head_data   [WR_COUNT];
  logic [BANK_COUNT-1:0] bank_grant;
  logic [PtrW-1:0]       bank_winner [BANK_COUNT];

  function automatic logic [SlotW-1:0] slot_inc(input logic [SlotW-1:0] slot);
    return (slot == SlotW'(BUF_ENTRIES - 1)) ? '0 : slot + 1'b1;
  endfunction

  // Ready depends only on registered occupancy, never on this cycle's dequeue.
  always_comb begin
    for (int i = 0; i < WR_COUNT; i++) begin
      not_full[i]   = (count_q[i] != CntW'(BUF_ENTRIES));
      head_valid[i] = (count_q[i] != '0);
      head_pr[i]    = fifo_pr_q[i][rd_slot_q[i]];
      head_data[i]  = fifo_data_q[i][rd_slot_q[i]];
    end
  end

  assign req_ready = not_full;
  assign enq       = req_valid & not_full;

  // Per-bank round-robin: scan from the bank pointer upward with wrap.
  always_comb begin
    logic [SumW-1:0] sum;
    logic [PtrW-1:0] idx;
    deq = '0;
    sum = '0;
    idx = '0;
    for (int b = 0; b < BANK_COUNT; b++) begin
      bank_grant[b]  = 1'b0;
      bank_winner[b] = '0;
      for (int k = 0; k < WR_COUNT; k++) begin
        sum = {1'b0, rr_ptr_q[b]} + SumW'(k);
        if (sum >= SumW'(WR_COUNT)) begin
          sum = sum - SumW'(WR_COUNT);
        end
        idx = sum[PtrW-1:0];
        if (!bank_grant[b] && head_valid[idx] &&
            (head_pr[idx][BankW-1:0] == BankW'(b))) begin
          bank_grant[b]  = 1'b1;
          bank_winner[b] = idx;
          deq[idx]       = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < WR_COUNT; i++) begin
        count_q[i]   <= '0;
        rd_slot_q[i] <= '0;
        wr_slot_q[i] <= '0;
      end
      for (int b = 0; b < BANK_COUNT; b++) begin
        rr_ptr_q[b] <= '0;
      end
      bank_wr_valid    <= '0;
      bank_wr_upper_PR <= '0;
      bank_wr_data     <= '0;
      bank_wr_PR       <= '0;
    end else begin
      for (int i = 0; i < WR_COUNT; i++) begin
        if (enq[i]) begin
          wr_slot_q[i] <= slot_inc(wr_slot_q[i]);
        end
        if (deq[i]) begin
          rd_slot_q[i] <= slot_inc(rd_slot_q[i]);
        end
        if (enq[i] && !deq[i]) begin
          count_q[i] <= count_q[i] + 1'b1;
        end else if (!enq[i] && deq[i]) begin
          count_q[i] <= count_q[i] - 1'b1;
        end
      end
      for (int b = 0; b < BANK_COUNT; b++) begin
        bank_wr_valid[b] <= bank_grant[b];
        if (bank_grant[b]) begin
          bank_wr_upper_PR[b] <= head_pr[bank_winner[b]][PrW-1:BankW];
          bank_wr_PR[b]       <= head_pr[bank_winner[b]];
          bank_wr_data[b]     <= head_data[bank_winner[b]];
          rr_ptr_q[b]         <= (bank_winner[b] == PtrW'(WR_COUNT - 1)) ? '0
                                                                          : bank_winner[b] + 1'b1;
        end
      end
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < WR_COUNT; i++) begin
      if (enq[i] && !RST) begin
        fifo_pr_q[i][wr_slot_q[i]]   <= req_PR[i];
        fifo_data_q[i][wr_slot_q[i]] <= req_data[i];
      end
    end
  end

endmodule
